// File: rtl/bist_response_analyzer.sv
// BIST output response analyzer: MISR compaction with golden-signature check.
// Optional per-response half-adder check enabled by BIST_ORA_CYCLE_CHECK_EN.
module bist_response_analyzer #(
  parameter int unsigned       SIG_W  = 8,
  parameter logic [SIG_W-1:0]  POLY   = SIG_W'(8'hB8),
  parameter logic [SIG_W-1:0]  SEED   = '0,
  parameter int unsigned       N_PAT  = 4,
  parameter logic [SIG_W-1:0]  GOLDEN = SIG_W'(8'h04)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             resp_valid,
  input  logic             sum,
  input  logic             car,
  input  logic             pat_a,
  input  logic             pat_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      pat_cnt
`ifdef BIST_ORA_CYCLE_CHECK_EN
  ,
  output logic [15:0]      fail_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(N_PAT - 1);

  state_t           state_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fb;

  assign fb    = ^(sig_q & POLY);
  assign sig_d = {sig_q[SIG_W-2:0], fb}
               ^ {{(SIG_W-2){1'b0}}, car, sum};
  assign cnt_d = cnt_q + 16'd1;

`ifdef BIST_ORA_CYCLE_CHECK_EN
  logic        mis_q;
  logic [15:0] fidx_q;
  logic        resp_bad;

  assign resp_bad = (sum != (pat_a ^ pat_b))
                 || (car != (pat_a & pat_b));
  assign fail_idx = fidx_q;
`else
  logic unused_pat;
  assign unused_pat = pat_a ^ pat_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef BIST_ORA_CYCLE_CHECK_EN
      mis_q   <= 1'b0;
      fidx_q  <= 16'hFFFF;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
`ifdef BIST_ORA_CYCLE_CHECK_EN
            mis_q   <= 1'b0;
            fidx_q  <= 16'hFFFF;
`endif
          end
        end
        RUN: begin
          if (resp_valid) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (cnt_q == LAST) begin
              state_q <= CHECK;
            end
`ifdef BIST_ORA_CYCLE_CHECK_EN
            // Only the first mismatch is recorded.
            if (resp_bad && !mis_q) begin
              mis_q  <= 1'b1;
              fidx_q <= cnt_q;
            end
`endif
          end
        end
        CHECK: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef BIST_ORA_CYCLE_CHECK_EN
          pass_q  <= (sig_q == GOLDEN) && !mis_q;
`else
          pass_q  <= (sig_q == GOLDEN);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboard bench for bist_response_analyzer with directed vectors.
// Macro BIST_ORA_CYCLE_CHECK_EN adds the per-response check scenarios.
module tb_bist_response_analyzer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        resp_valid = 1'b0;
  logic        sum = 1'b0;
  logic        car = 1'b0;
  logic        pat_a = 1'b0;
  logic        pat_b = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  signature;
  logic [15:0] pat_cnt;
  logic [15:0] fail_idx;

  bist_response_analyzer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .resp_valid (resp_valid),
    .sum        (sum),
    .car        (car),
    .pat_a      (pat_a),
    .pat_b      (pat_b),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
`ifdef BIST_ORA_CYCLE_CHECK_EN
    .pat_cnt    (pat_cnt),
    .fail_idx   (fail_idx)
`else
    .pat_cnt    (pat_cnt)
`endif
  );

`ifndef BIST_ORA_CYCLE_CHECK_EN
  assign fail_idx = 16'hFFFF;
`endif

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]  sig;
    logic        pass;
    logic [15:0] fidx;
  } exp_t;

  exp_t sbq[$];

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_sig", 32'(signature), 32'(e.sig));
        chk("sb_pass", 32'(pass), 32'(e.pass));
`ifdef BIST_ORA_CYCLE_CHECK_EN
        chk("sb_fidx", 32'(fail_idx), 32'(e.fidx));
`endif
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_sig", 32'(signature), 32'h00);
    chk("start_cnt", 32'(pat_cnt), 32'd0);
    chk("start_pass", 32'(pass), 32'd0);
  endtask

  task automatic resp(input logic [1:0] cs,
                      input logic [1:0] ab,
                      input logic [7:0] es);
    resp_valid = 1'b1;
    {car, sum} = cs;
    {pat_a, pat_b} = ab;
    @(negedge clk);
    chk("sig_step", 32'(signature), 32'(es));
  endtask

  task automatic idle_n(input int n, input logic [7:0] es);
    resp_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("busy_gap", 32'(busy), 32'd1);
      chk("sig_hold", 32'(signature), 32'(es));
    end
  endtask

  task automatic run(input logic [7:0]  rs,
                     input logic [31:0] es,
                     input logic [7:0]  gsig,
                     input logic        gpass,
                     input logic [15:0] gfidx,
                     input int          gap,
                     input bit          st,
                     input bit          b2b);
    exp_t e;
    e.sig  = gsig;
    e.pass = gpass;
    e.fidx = gfidx;
    sbq.push_back(e);
    if (st) do_start();
    for (int i = 0; i < 4; i++) begin
      resp(rs[7-2*i -: 2], 2'(i), es[31-8*i -: 8]);
      if (gap > 0 && i < 3) idle_n(gap, es[31-8*i -: 8]);
    end
    resp_valid = 1'b0;
    @(negedge clk);
    chk("done_latency", 32'(done), 32'd1);
    if (b2b) begin
      do_start();
      chk("b2b_done_low", 32'(done), 32'd0);
    end else begin
      @(negedge clk);
      chk("done_pulse_end", 32'(done), 32'd0);
      chk("pass_hold", 32'(pass), 32'(gpass));
    end
  endtask

  task automatic reset_checks();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_sig", 32'(signature), 32'd0);
    chk("rst_cnt", 32'(pat_cnt), 32'd0);
`ifdef BIST_ORA_CYCLE_CHECK_EN
    chk("rst_fidx", 32'(fail_idx), 32'hFFFF);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    @(negedge clk);

    run(8'b00_01_01_10, 32'h00010304, 8'h04, 1'b1, 16'hFFFF, 0, 1, 0);
    run(8'b00_01_01_11, 32'h00010305, 8'h05, 1'b0, 16'd3, 0, 1, 0);
    run(8'b00_01_01_10, 32'h00010304, 8'h04, 1'b1, 16'hFFFF, 3, 1, 0);

    do_start();
    resp(2'b00, 2'b00, 8'h00);
    resp(2'b01, 2'b01, 8'h01);
    resp_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrun_start_cnt", 32'(pat_cnt), 32'd2);
    chk("midrun_start_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(8'b00_01_01_10, 32'h00010304, 8'h04, 1'b1, 16'hFFFF, 0, 1, 0);

`ifdef BIST_ORA_CYCLE_CHECK_EN
    run(8'b00_01_00_10, 32'h00010206, 8'h06, 1'b0, 16'd2, 0, 1, 0);
`endif

    run(8'b00_01_01_10, 32'h00010304, 8'h04, 1'b1, 16'hFFFF, 0, 1, 1);
    run(8'b00_01_01_10, 32'h00010304, 8'h04, 1'b1, 16'hFFFF, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_response_analyzer.md
# bist_response_analyzer

Output response analyzer for the BIST path: it sits at the receiving end of the circuit under test (CUT). It accepts each registered CUT response (`sum`, `car`) and compacts it into a multiple-input signature register (MISR). After `N_PAT` accepted responses it compares the signature with a golden value and reports pass/fail through a start/done handshake. It is the reader counterpart to the test-pattern generator that drives the CUT inputs.

## Interface
Parameters:
- `SIG_W`, 8, MISR width; legal range 4..32.
- `POLY`, 8'hB8, feedback tap mask (x^8+x^6+x^5+x^4+1).
- `SEED`, 0, value loaded into the MISR on each accepted `start`.
- `N_PAT`, 4, responses per test run; legal range 1..2^16-1.
- `GOLDEN`, 8'h04, expected final signature. The default is exhaustive half-adder patterns in order ab = 00, 01, 10, 11.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a run.
- `resp_valid`  in  1  CUT response valid this cycle.
- `sum`  in  1  CUT sum response.
- `car`  in  1  CUT carry response.
- `pat_a`  in  1  pattern input `a` applied to the CUT for this response. Used only with `BIST_ORA_CYCLE_CHECK_EN`.
- `pat_b`  in  1  pattern input `b`, same condition as `pat_a`.
- `busy`  out  1  high in RUN and CHECK.
- `done`  out  1  one-cycle pulse when the result is valid.
- `pass`  out  1  result of the last run; held until the next accepted `start`.
- `signature`  out  SIG_W  current MISR contents.
- `pat_cnt`  out  16  responses accepted in the current run.
- `fail_idx`  out  16  index of the first mismatching response. Present only with `BIST_ORA_CYCLE_CHECK_EN`.

## Operation
- States: IDLE, RUN, CHECK, DONE.
- IDLE/DONE -> RUN on `start`. Entering RUN loads `signature` <= SEED, clears `pat_cnt`, clears `pass`, and clears the mismatch flag.
- `start` is ignored while in RUN or CHECK. A run cannot be aborted except by reset.
- In RUN, each cycle with `resp_valid`=1 does two things:
  - Feedback bit: `fb` = XOR-reduce(`signature` & POLY).
  - MISR update: `signature` <= {`signature`[SIG_W-2:0], `fb`} ^ {0…0, `car`, `sum`}, with the response in bits [1:0].
  - The same edge sets `pat_cnt` <= `pat_cnt`+1.
- The response that makes `pat_cnt` reach N_PAT moves the FSM RUN -> CHECK. `resp_valid` is ignored outside RUN.
- `resp_valid`=0 in RUN is a stall: the MISR and counter hold.
- CHECK -> DONE unconditionally after one cycle. On that transition, `pass` <= (`signature` == GOLDEN) [&& !mismatch with the macro], and `done` <= 1.
- DONE: `done` returns to 0 after one cycle. `pass` and `signature` hold until the next `start`.
- Reset, including mid-run: state IDLE; `busy`, `done`, `pass` = 0; `signature` = 0; `pat_cnt` = 0; `fail_idx` = 16'hFFFF.

## Timing
- `start` sampled at edge k -> `busy`=1 and `signature`=SEED after edge k.
- The last valid response is accepted at edge m. CHECK runs for cycle m..m+1. `done`=1 and `pass` are valid after edge m+1. `done`=0 after edge m+2.
- Minimum run length: N_PAT+2 cycles from `start` to `done`.
- A `start` in the same cycle as `done` (state DONE) is accepted.
- `start` and `resp_valid` in the same cycle while in IDLE/DONE: the response is discarded.
- `pat_cnt` never exceeds N_PAT.

## Configuration
- `BIST_ORA_CYCLE_CHECK_EN` defined:
  - Each accepted response is also compared with the expected half-adder result: `sum` == `pat_a`^`pat_b` and `car` == `pat_a`&`pat_b`.
  - On the first mismatch, the mismatch flag is set and `fail_idx` <= `pat_cnt` (pre-increment value).
  - The flag forces `pass`=0 even if the signature matches, which covers aliasing.
- Not defined:
  - `pat_a` and `pat_b` are unused.
  - There is no `fail_idx` port.
  - `pass` depends on the signature alone.

## Test plan
- Defaults. `start`, then (`car`,`sum`) = 00, 01, 01, 10 on consecutive valid cycles -> `signature` 01, 03, 04; `done` pulse with `pass`=1 and `signature`=8'h04, 2 cycles after the last response.
- Same run, but the last response is 11 -> final `signature`=8'h05, `pass`=0.
- Gaps of 3 cycles with `resp_valid`=0 between the responses of the first scenario -> identical final signature 8'h04 and `pass`=1; `busy` stays high throughout.
- Assert `rst_n`=0 after 2 responses, release, then run the first scenario -> all outputs 0 during reset; the run after reset passes with 8'h04. A `start` pulsed mid-run has no effect on `pat_cnt`.
- With the macro, `pat_a`,`pat_b` = 00, 01, 10, 11 and responses 00, 01, 00, 10 -> `fail_idx`=2, `pass`=0.
- With the macro and the first scenario plus a matching ab sequence -> `pass`=1, `fail_idx`=16'hFFFF. A back-to-back `start` in the `done` cycle begins a new run with `signature`=SEED.
